// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter.
// Contents: arbiter FSM state, grant owner, and pending operation encodings,
// plus the byte-offset width of a 256-bit cacheline.
package cache_arbiter_pkg;

  // 256-bit line = 32 bytes, so the low 5 address bits select a byte in the line.
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter_checker.sv
// Protocol assertions for cache_arbiter.
// Ports: clk, reset_n, the arbiter's FSM state, the dcache request strobes,
// and the pmem request strobes.
module cache_arbiter_checker
  import cache_arbiter_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  input arb_state_t state,
  input logic       d_read,
  input logic       d_write,
  input logic       pmem_read,
  input logic       pmem_write
);

  // The dcache must never ask for a fill and a write-back at the same time;
  // the arbiter treats such a request as a write-back.
  assert property (@(posedge clk) disable iff (!reset_n)
                   !((state == IDLE) && d_read && d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");

  // The adaptor is only ever given one operation at a time.
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(pmem_read && pmem_write))
    else $error("cache_arbiter: pmem_read and pmem_write asserted together");

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between the icache and dcache line ports and the single
// pmem port of the cacheline adaptor.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_address/i_read             icache line-read request (held until i_resp)
//   i_rdata/i_resp               returned line and one-cycle completion pulse
//   d_address/d_read/d_write     dcache request (held until d_resp)
//   d_wdata                      dcache write-back line
//   d_rdata/d_resp               returned line and one-cycle completion pulse
//   pmem_address/read/write      line-aligned request to the adaptor
//   pmem_wdata                   write-back line to the adaptor
//   pmem_rdata/pmem_resp         line and completion from the adaptor
// Every pmem-side output comes straight from a register, so there is no
// combinational path from either cache to the adaptor.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    {{(ADDR_WIDTH-LINE_OFFSET_BITS){1'b0}}, {LINE_OFFSET_BITS{1'b1}}};

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

  arb_state_t            state_r, state_s;
  arb_owner_t            owner_r, owner_s;
  arb_owner_t            last_grant_r, last_grant_s;
  arb_op_t               op_r, op_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [LINE_WIDTH-1:0] wdata_r, wdata_s;
  logic [LINE_WIDTH-1:0] line_r, line_s;
  logic                  pmem_read_r, pmem_read_s;
  logic                  pmem_write_r, pmem_write_s;
  logic                  i_resp_r, i_resp_s;
  logic                  d_resp_r, d_resp_s;
  logic                  req_i_s, req_d_s, grant_d_s;

  // Next-state, grant selection and next output values.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    op_s         = op_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    line_s       = line_r;
    pmem_read_s  = 1'b0;
    pmem_write_s = 1'b0;
    i_resp_s     = 1'b0;
    d_resp_s     = 1'b0;
    req_i_s      = i_read;
    req_d_s      = d_read | d_write;
    grant_d_s    = 1'b0;

    case (state_r)
      IDLE: begin
        // On a tie the cache that did not win last time goes next.
        if (req_i_s && req_d_s) begin
          grant_d_s = (last_grant_r == OWNER_I);
        end else begin
          grant_d_s = req_d_s;
        end

        if (req_i_s || req_d_s) begin
          state_s = SERVE;
          if (grant_d_s) begin
            owner_s      = OWNER_D;
            last_grant_s = OWNER_D;
            addr_s       = line_align(d_address);
            // A simultaneous read+write from the dcache resolves to the write-back.
            if (d_write) begin
              op_s         = OP_WRITE;
              wdata_s      = d_wdata;
              pmem_write_s = 1'b1;
            end else begin
              op_s        = OP_READ;
              wdata_s     = {LINE_WIDTH{1'b0}};
              pmem_read_s = 1'b1;
            end
          end else begin
            owner_s      = OWNER_I;
            last_grant_s = OWNER_I;
            addr_s       = line_align(i_address);
            op_s         = OP_READ;
            wdata_s      = {LINE_WIDTH{1'b0}};
            pmem_read_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SERVE: begin
        if (pmem_resp) begin
          // Captured for write-backs too; the dcache simply ignores it.
          line_s  = pmem_rdata;
          state_s = RESP;
          if (owner_r == OWNER_D) begin
            d_resp_s = 1'b1;
          end else begin
            i_resp_s = 1'b1;
          end
        end else begin
          pmem_read_s  = (op_r == OP_READ);
          pmem_write_s = (op_r == OP_WRITE);
        end
      end

      RESP: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the pmem strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      owner_r      <= OWNER_I;
      last_grant_r <= OWNER_I;
      op_r         <= OP_READ;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r      <= {LINE_WIDTH{1'b0}};
      line_r       <= {LINE_WIDTH{1'b0}};
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      op_r         <= op_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      line_r       <= line_s;
      pmem_read_r  <= pmem_read_s;
      pmem_write_r <= pmem_write_s;
      i_resp_r     <= i_resp_s;
      d_resp_r     <= d_resp_s;
    end
  end

  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;
  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign i_resp       = i_resp_r;
  assign d_resp       = d_resp_r;
  // Both caches see the same returned line; only the resp pulse qualifies it.
  assign i_rdata      = line_r;
  assign d_rdata      = line_r;

  cache_arbiter_checker u_checker (
    .clk        (clk),
    .reset_n    (reset_n),
    .state      (state_r),
    .d_read     (d_read),
    .d_write    (d_write),
    .pmem_read  (pmem_read_r),
    .pmem_write (pmem_write_r)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed latency/ordering scenarios
// followed by randomized traffic from both caches against a memory model.
module tb_cache_arbiter;

  logic         clk;
  logic         reset_n;
  logic [31:0]  i_address;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic wr; logic [255:0] data; } d_exp_t;
  typedef struct packed { logic [31:0] addr; logic wr; logic [255:0] wdata; } pm_exp_t;

  logic [255:0] exp_i_q[$];
  d_exp_t       exp_d_q[$];
  pm_exp_t      exp_pm_i_q[$];
  pm_exp_t      exp_pm_d_q[$];
  logic [255:0] mem_model[logic [31:0]];
  logic [255:0] pmem_store[logic [31:0]];

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b00000};
  endfunction

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [255:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat(a);
  endfunction

  function automatic logic [255:0] store_read(input logic [31:0] a);
    if (pmem_store.exists(a)) return pmem_store[a];
    return pat(a);
  endfunction

  task automatic issue_i(input logic [31:0] a);
    pm_exp_t e;
    e.addr = align(a); e.wr = 1'b0; e.wdata = 256'h0;
    exp_i_q.push_back(model_read(align(a)));
    exp_pm_i_q.push_back(e);
    i_address = a;
    i_read    = 1'b1;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic wr, input logic [255:0] wd);
    pm_exp_t e;
    d_exp_t  r;
    e.addr = align(a); e.wr = wr; e.wdata = wr ? wd : 256'h0;
    r.wr = wr;
    if (wr) begin
      mem_model[align(a)] = wd;
      r.data = 256'h0;
    end else begin
      r.data = model_read(align(a));
    end
    exp_d_q.push_back(r);
    exp_pm_d_q.push_back(e);
    d_address = a;
    d_wdata   = wd;
    d_read    = !wr;
    d_write   = wr;
  endtask

  // Wait (bounded) for i_resp, counting negedges from 'start'; then drop the request.
  task automatic wait_i(input int start, output int at);
    at = start;
    while (!i_resp && at < start + 300) begin
      @(negedge clk);
      at++;
    end
    check("i_resp_timeout", 256'(i_resp), 256'(1));
    i_read = 1'b0;
  endtask

  task automatic wait_d(input int start, output int at);
    at = start;
    while (!d_resp && at < start + 300) begin
      @(negedge clk);
      at++;
    end
    check("d_resp_timeout", 256'(d_resp), 256'(1));
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // ---------------- memory responder ----------------
  int fixed_lat   = 5;
  bit spurious_en = 1'b0;
  int pm_cnt      = 0;
  bit pm_busy     = 1'b0;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = 256'h0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!reset_n) begin
        pm_busy = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (!pm_busy) begin
          pm_busy = 1'b1;
          pm_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        end
        pm_cnt--;
        if (pm_cnt == 0) begin
          pm_busy   = 1'b0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pmem_store[pmem_address] = pmem_wdata;
            pmem_rdata = {8{$urandom}};
          end else begin
            pmem_rdata = store_read(pmem_address);
          end
        end
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {8{$urandom}};
      end
    end
  end

  // ---------------- monitors ----------------
  // Requests as seen by the DUT at each rising edge (inputs only change at negedges).
  logic req_i_q = 1'b0;
  logic req_d_q = 1'b0;
  initial forever begin
    @(posedge clk);
    req_i_q = i_read;
    req_d_q = d_read | d_write;
  end

  logic last_owner_d = 1'b0;
  logic pm_prev      = 1'b0;
  logic i_resp_prev  = 1'b0;
  logic d_resp_prev  = 1'b0;

  initial forever begin
    logic    pm_now;
    logic    owner_d;
    pm_exp_t e;
    d_exp_t  r;
    @(negedge clk);
    if (!reset_n) begin
      last_owner_d = 1'b0;
      pm_prev      = 1'b0;
      i_resp_prev  = 1'b0;
      d_resp_prev  = 1'b0;
    end else begin
      pm_now = pmem_read | pmem_write;
      if (pm_now && !pm_prev) begin
        // Grant was made from the requests present one edge earlier.
        if (req_i_q && req_d_q) owner_d = !last_owner_d;
        else                    owner_d = req_d_q;
        last_owner_d = owner_d;
        check("pmem_rw_exclusive", 256'(pmem_read & pmem_write), 256'(0));
        if (owner_d) begin
          check("pmem_d_expected", 256'(exp_pm_d_q.size() > 0), 256'(1));
          if (exp_pm_d_q.size() > 0) begin
            e = exp_pm_d_q.pop_front();
            check("pmem_d_addr", 256'(pmem_address), 256'(e.addr));
            check("pmem_d_write", 256'(pmem_write), 256'(e.wr));
            if (e.wr) check("pmem_d_wdata", pmem_wdata, e.wdata);
          end
        end else begin
          check("pmem_i_expected", 256'(exp_pm_i_q.size() > 0), 256'(1));
          if (exp_pm_i_q.size() > 0) begin
            e = exp_pm_i_q.pop_front();
            check("pmem_i_addr", 256'(pmem_address), 256'(e.addr));
            check("pmem_i_read", 256'(pmem_read), 256'(1));
          end
        end
      end
      pm_prev = pm_now;

      if (i_resp) begin
        check("i_resp_single_cycle", 256'(i_resp_prev), 256'(0));
        check("i_resp_expected", 256'(exp_i_q.size() > 0), 256'(1));
        if (exp_i_q.size() > 0) check("i_rdata", i_rdata, exp_i_q.pop_front());
      end
      i_resp_prev = i_resp;

      if (d_resp) begin
        check("d_resp_single_cycle", 256'(d_resp_prev), 256'(0));
        check("d_resp_expected", 256'(exp_d_q.size() > 0), 256'(1));
        if (exp_d_q.size() > 0) begin
          r = exp_d_q.pop_front();
          if (!r.wr) check("d_rdata", d_rdata, r.data);
        end
      end
      d_resp_prev = d_resp;
    end
  end

  // ---------------- random traffic ----------------
  task automatic run_i(input int n);
    int at;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue_i($urandom & 32'h0000_0FFF);
      wait_i(0, at);
      @(negedge clk);
    end
  endtask

  task automatic run_d(input int n);
    int at;
    logic wr;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr = ($urandom_range(0, 1) == 1);
      issue_d(32'h8000_0000 | ($urandom & 32'h0000_01FF), wr, {8{$urandom}});
      wait_d(0, at);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int at, at2, at3;
    reset_n = 1'b0;
    i_address = 32'h0; i_read = 1'b0;
    d_address = 32'h0; d_read = 1'b0; d_write = 1'b0; d_wdata = 256'h0;
    repeat (2) @(negedge clk);
    check("rst_pmem_read", 256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_pmem_address", 256'(pmem_address), 256'(0));
    check("rst_resp", 256'({i_resp, d_resp}), 256'(0));
    check("rst_rdata", i_rdata | d_rdata | pmem_wdata, 256'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Lone icache read with a known line.
    fixed_lat = 5;
    pmem_store[32'h0000_1040] = {8{32'hDEADBEEF}};
    mem_model[32'h0000_1040]  = {8{32'hDEADBEEF}};
    issue_i(32'h0000_1040);
    @(negedge clk);
    check("t1_pmem_read", 256'(pmem_read), 256'(1));
    check("t1_pmem_write", 256'(pmem_write), 256'(0));
    check("t1_pmem_address", 256'(pmem_address), 256'(32'h0000_1040));
    wait_i(1, at);
    check("t1_i_resp_cycle", 256'(at), 256'(6));
    check("t1_i_rdata", i_rdata, {8{32'hDEADBEEF}});
    @(negedge clk);

    // Dcache write-back; data must be frozen at grant.
    issue_d(32'h8000_00E0, 1'b1, {32{8'hA5}});
    @(negedge clk);
    check("t2_pmem_write", 256'(pmem_write), 256'(1));
    check("t2_pmem_read", 256'(pmem_read), 256'(0));
    check("t2_pmem_wdata", pmem_wdata, {32{8'hA5}});
    d_wdata = 256'h0;
    @(negedge clk);
    check("t2_wdata_held", pmem_wdata, {32{8'hA5}});
    wait_d(2, at);
    check("t2_d_resp_cycle", 256'(at), 256'(6));
    @(negedge clk);
    issue_d(32'h8000_00E4, 1'b0, 256'h0);
    wait_d(0, at);
    @(negedge clk);

    // Simultaneous requests after reset: D first; D re-requests at once so I wins next.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    fixed_lat = 3;
    issue_i(32'h0000_2000);
    issue_d(32'h8000_0040, 1'b0, 256'h0);
    wait_d(0, at);
    check("t3_d_first_cycle", 256'(at), 256'(4));
    @(negedge clk);
    issue_d(32'h8000_0060, 1'b0, 256'h0);
    wait_i(5, at2);
    check("t3_i_second_cycle", 256'(at2), 256'(9));
    wait_d(at2, at3);
    check("t3_d_third_cycle", 256'(at3), 256'(14));
    @(negedge clk);

    // Unaligned icache address.
    fixed_lat = 2;
    issue_i(32'h0000_105C);
    @(negedge clk);
    check("t4_aligned_addr", 256'(pmem_address), 256'(32'h0000_1040));
    wait_i(1, at);
    @(negedge clk);

    // Icache request while dcache is being served.
    fixed_lat = 5;
    issue_d(32'h8000_0100, 1'b0, 256'h0);
    @(negedge clk);
    @(negedge clk);
    issue_i(32'h0000_3000);
    @(negedge clk);
    check("t5_d_still_owner", 256'(pmem_address), 256'(32'h8000_0100));
    wait_d(3, at);
    check("t5_d_resp_cycle", 256'(at), 256'(6));
    at2 = at;
    while (!pmem_read && at2 < at + 20) begin
      @(negedge clk);
      at2++;
    end
    check("t5_i_pmem_rise_cycle", 256'(at2), 256'(8));
    wait_i(at2, at3);
    check("t5_i_resp_cycle", 256'(at3), 256'(13));
    @(negedge clk);

    // Reset in the middle of SERVE; the held request is replayed afterwards.
    issue_i(32'h0000_3040);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_async_drop", 256'({pmem_read, pmem_write}), 256'(0));
    @(negedge clk);
    check("t6_no_resp_in_reset", 256'({i_resp, d_resp}), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    begin
      pm_exp_t e;
      e.addr = 32'h0000_3040; e.wr = 1'b0; e.wdata = 256'h0;
      exp_pm_i_q.push_back(e);
    end
    wait_i(0, at);
    check("t6_replay_resp_cycle", 256'(at), 256'(6));
    @(negedge clk);

    // Randomized traffic from both caches with random memory latency.
    fixed_lat   = 0;
    spurious_en = 1'b1;
    fork
      run_i(40);
      run_d(40);
    join
    spurious_en = 1'b0;
    repeat (10) @(negedge clk);
    check("drain_i", 256'(exp_i_q.size()), 256'(0));
    check("drain_d", 256'(exp_d_q.size()), 256'(0));
    check("drain_pmem", 256'(exp_pm_i_q.size() + exp_pm_d_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits between the split instruction and data caches and the cacheline_adaptor.
- Multiplexes two 256-bit line-fill/write-back requesters onto the single pmem port that the adaptor bursts to memory.
- Round-robin on simultaneous requests.
- Request is registered on grant, so pmem-side outputs have no combinational path from either cache.

Parameters:
ADDR_WIDTH, 32, address width on all ports
LINE_WIDTH, 256, cacheline width in bits; offset bits = log2(LINE_WIDTH/8) = 5

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
i_address  input  ADDR_WIDTH  icache line address
i_read  input  1  icache line-read request, held until i_resp
i_rdata  output  LINE_WIDTH  line returned to icache
i_resp  output  1  one-cycle completion pulse to icache
d_address  input  ADDR_WIDTH  dcache line address
d_read  input  1  dcache line-read request, held until d_resp
d_write  input  1  dcache write-back request, held until d_resp
d_wdata  input  LINE_WIDTH  dcache write-back line
d_rdata  output  LINE_WIDTH  line returned to dcache
d_resp  output  1  one-cycle completion pulse to dcache
pmem_address  output  ADDR_WIDTH  to adaptor address_i, line-aligned
pmem_read  output  1  to adaptor read_i
pmem_write  output  1  to adaptor write_i
pmem_wdata  output  LINE_WIDTH  to adaptor line_i
pmem_rdata  input  LINE_WIDTH  from adaptor line_o
pmem_resp  input  1  from adaptor resp_o

Behaviour:
- States: IDLE, SERVE, RESP. Registers: state, owner (I/D), last_grant, addr_q, wdata_q, op_q (read/write), line_q.
- Reset (async on reset_n low, regardless of state):
  - state=IDLE; all outputs 0; line_q=0; last_grant=I (first tie goes to D).
- IDLE:
  - If no request: stay in IDLE.
  - Only one cache requesting: grant it.
  - Both requesting: grant the cache that is not last_grant.
  - On grant:
    - addr_q = address with low 5 bits cleared.
    - wdata_q = d_wdata for a D write.
    - op_q: D with both d_read and d_write high is illegal; simulation assertion fires and the request is treated as a write.
    - Update owner and last_grant; go to SERVE.
- SERVE:
  - pmem_address=addr_q; pmem_read=(op_q==read); pmem_write=(op_q==write); pmem_wdata=wdata_q. All held stable until pmem_resp.
  - Changes on cache inputs are ignored.
  - On pmem_resp: line_q=pmem_rdata (captured for writes too, ignored by the cache); go to RESP.
- RESP:
  - pmem_read/pmem_write=0.
  - Owner's resp=1 for exactly one cycle; other resp=0.
  - Go to IDLE.
- i_rdata and d_rdata are both driven from line_q. Only the resp pulse qualifies the data.
- Latency:
  - Request seen in IDLE at cycle 0 → pmem_read/pmem_write high at cycle 1.
  - pmem_resp at cycle N → owner resp at cycle N+1.
  - IDLE at N+2; the next grant is taken at N+2, so the earliest next pmem request is N+3.
- Caches must drop their request the cycle after resp. Because the arbiter samples in IDLE only after RESP, a request is never double-served.
- A request arriving while non-IDLE is held by the cache and granted in the next IDLE. The loser of a tie is guaranteed service next, so there is no starvation.
- pmem_read and pmem_write are never both 1. Neither is asserted outside SERVE.
- pmem_resp outside SERVE is ignored.

Decomposition:
- Add to rv32i_types (shared package):
  - arb_state_t enum {IDLE, SERVE, RESP}
  - arb_owner_t enum {OWNER_I, OWNER_D}
  - localparam LINE_OFFSET_BITS = 5
- Flat module, no sub-module; the grant selection is a few lines of combinational logic inside the IDLE branch.
- Instantiated in the top level between the caches and cacheline_adaptor, replacing the direct cache→adaptor connection.

Test Plan:
- I read 0x0000_1040 alone:
  - pmem_read=1, pmem_address=0x0000_1040 at cycle 1.
  - pmem_resp at cycle 5 with line 0x…DEADBEEF pattern → i_resp=1 at cycle 6 with i_rdata equal to that pattern; d_resp=0 throughout.
- D write-back 0x8000_00E0, d_wdata=all 0xA5:
  - pmem_write=1, pmem_wdata all 0xA5, pmem_read=0.
  - d_resp one cycle after pmem_resp.
  - d_wdata changed to 0 mid-SERVE → pmem_wdata stays 0xA5.
- Simultaneous I/D after reset: D served first, then I. Immediately re-issue both simultaneously → I served first (alternation).
- Unaligned i_address 0x0000_105C → pmem_address=0x0000_1040.
- I requests while D in SERVE → I not visible on pmem until D's RESP completes; I granted in following IDLE; pmem_read for I rises exactly 3 cycles after D's pmem_resp.
- reset_n low during SERVE → pmem_read/pmem_write drop immediately (asynchronously); no resp pulse. After release, re-held request served normally with correct data.
